// File: rtl/isr_sequencer_if.sv
// Handshake bundle between isr_sequencer, the interrupt controller and the datapath PC/flag registers.
// The slave modport is the sequencer's view; master is the surrounding environment's view.
interface isr_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int FLAG_W = 4
);
  logic              i_pending;
  logic [PC_W-1:0]   isr_addr;
  logic [PC_W-1:0]   pc_next;
  logic [FLAG_W-1:0] flags_in;
  logic              instr_done;
  logic              reti;
  logic              gie_set;
  logic              gie_clr;

  logic              irq_enable;
  logic              i_clr;
  logic              pc_load;
  logic [PC_W-1:0]   pc_load_val;
  logic              flags_restore;
  logic [FLAG_W-1:0] flags_out;
  logic              stall;
  logic              in_isr;
  logic              reti_err;

  modport slave (
    input  i_pending, isr_addr, pc_next, flags_in, instr_done, reti, gie_set, gie_clr,
    output irq_enable, i_clr, pc_load, pc_load_val, flags_restore, flags_out, stall,
           in_isr, reti_err
  );

  modport master (
    output i_pending, isr_addr, pc_next, flags_in, instr_done, reti, gie_set, gie_clr,
    input  irq_enable, i_clr, pc_load, pc_load_val, flags_restore, flags_out, stall,
           in_isr, reti_err
  );
endinterface

// File: rtl/isr_sequencer.sv
// Takes pending interrupts at instruction boundaries: saves return PC/flags, vectors, restores on reti.
// Define NESTED_IRQ_EN for a NEST_DEPTH-deep LIFO frame stack; default build keeps a single frame.
module isr_sequencer #(
  parameter int PC_W       = 8,
  parameter int FLAG_W     = 4,
  parameter int NEST_DEPTH = 4
) (
  input logic            clk,
  input logic            clr,
  isr_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACK, VECTOR, ISR, RET} state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [FLAG_W-1:0] flags;
  } frame_t;

  if (NEST_DEPTH < 1) begin : g_bad_depth
    $error("isr_sequencer: NEST_DEPTH must be at least 1");
  end

  state_t          state;
  logic            gie;
  logic [PC_W-1:0] vec;
  frame_t          push_frame;
  frame_t          top;
  logic            room;
  logic            accept;
  logic            ret_req;
  logic            push;

`ifdef NESTED_IRQ_EN
  localparam int DEPTH = NEST_DEPTH;
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  frame_t          stack [DEPTH];
  logic [SP_W-1:0] sp;

  assign room = (sp < SP_W'(DEPTH));
  assign top  = stack[IDX_W'(sp - 1'b1)];
`else
  frame_t frame;
  logic   valid;

  assign room = !valid;
  assign top  = frame;
`endif

  assign push_frame = '{pc: bus.pc_next, flags: bus.flags_in};
  assign bus.irq_enable = gie & ((state == IDLE) | ((state == ISR) & room));
  assign accept  = bus.instr_done & bus.i_pending & bus.irq_enable;
  assign ret_req = bus.instr_done & bus.reti;
  // A reti retiring in ISR wins over a same-cycle interrupt.
  assign push    = accept & !((state == ISR) & ret_req);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state             <= IDLE;
      gie               <= 1'b0;
      vec               <= '0;
      bus.i_clr         <= 1'b0;
      bus.pc_load       <= 1'b0;
      bus.pc_load_val   <= '0;
      bus.flags_restore <= 1'b0;
      bus.flags_out     <= '0;
      bus.stall         <= 1'b0;
      bus.in_isr        <= 1'b0;
      bus.reti_err      <= 1'b0;
`ifdef NESTED_IRQ_EN
      sp <= '0;
      // NOTE: the frame stack is tiny and must read as empty after reset, so it is reset like any flop.
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
`else
      frame <= '0;
      valid <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch sees pre-edge register values.
      bus.i_clr         <= 1'b0;
      bus.pc_load       <= 1'b0;
      bus.flags_restore <= 1'b0;
      bus.stall         <= 1'b0;
      bus.in_isr        <= 1'b0;
      bus.reti_err      <= 1'b0;

      if (bus.gie_clr)      gie <= 1'b0;
      else if (bus.gie_set) gie <= 1'b1;

`ifdef NESTED_IRQ_EN
      if (push) begin
        stack[IDX_W'(sp)] <= push_frame;
        sp                <= sp + 1'b1;
      end else if (state == RET) begin
        sp <= sp - 1'b1;
      end
`else
      if (push) begin
        frame <= push_frame;
        valid <= 1'b1;
      end else if (state == RET) begin
        valid <= 1'b0;
      end
`endif

      case (state)
        IDLE: begin
          if (push) begin
            vec       <= bus.isr_addr;
            bus.i_clr <= 1'b1;
            bus.stall <= 1'b1;
            state     <= ACK;
          end else if (ret_req) begin
            bus.reti_err <= 1'b1;
          end
        end
        ACK: begin
          bus.pc_load     <= 1'b1;
          bus.pc_load_val <= vec;
          bus.stall       <= 1'b1;
          state           <= VECTOR;
        end
        VECTOR: begin
          bus.in_isr <= 1'b1;
          state      <= ISR;
        end
        ISR: begin
          if (ret_req) begin
            bus.pc_load       <= 1'b1;
            bus.pc_load_val   <= top.pc;
            bus.flags_restore <= 1'b1;
            bus.flags_out     <= top.flags;
            bus.stall         <= 1'b1;
            state             <= RET;
          end else if (push) begin
            vec       <= bus.isr_addr;
            bus.i_clr <= 1'b1;
            bus.stall <= 1'b1;
            state     <= ACK;
          end else begin
            bus.in_isr <= 1'b1;
          end
        end
        RET: begin
`ifdef NESTED_IRQ_EN
          if (sp != SP_W'(1)) begin
            bus.in_isr <= 1'b1;
            state      <= ISR;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isr_sequencer.sv
// Directed bench for isr_sequencer: step-by-step checks plus a pc_load scoreboard fed at stimulus time.
// Builds with or without NESTED_IRQ_EN; nested scenarios run only when it is defined.
module tb_isr_sequencer;
  localparam int PC_W       = 8;
  localparam int FLAG_W     = 4;
  localparam int NEST_DEPTH = 4;
`ifdef NESTED_IRQ_EN
  localparam bit NESTED = 1'b1;
`else
  localparam bit NESTED = 1'b0;
`endif

  typedef struct {
    logic [PC_W-1:0]   pc;
    bit                restore;
    logic [FLAG_W-1:0] flags;
  } load_t;

  logic  clk = 1'b0;
  logic  clr = 1'b0;
  int    checks = 0;
  int    errors = 0;
  load_t exp_q[$];
  load_t got;

  isr_sequencer_if #(.PC_W(PC_W), .FLAG_W(FLAG_W)) bus ();

  isr_sequencer #(.PC_W(PC_W), .FLAG_W(FLAG_W), .NEST_DEPTH(NEST_DEPTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boundary(input bit r);
    bus.instr_done = 1'b1;
    bus.reti       = r;
    tick();
    bus.instr_done = 1'b0;
    bus.reti       = 1'b0;
  endtask

  task automatic expect_load(input logic [PC_W-1:0] pc, input bit restore,
                             input logic [FLAG_W-1:0] flags);
    load_t e;
    e.pc      = pc;
    e.restore = restore;
    e.flags   = flags;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_irq_enable"}, bus.irq_enable, 0);
    check({tag, "_i_clr"}, bus.i_clr, 0);
    check({tag, "_pc_load"}, bus.pc_load, 0);
    check({tag, "_pc_load_val"}, bus.pc_load_val, 0);
    check({tag, "_flags_restore"}, bus.flags_restore, 0);
    check({tag, "_flags_out"}, bus.flags_out, 0);
    check({tag, "_stall"}, bus.stall, 0);
    check({tag, "_in_isr"}, bus.in_isr, 0);
    check({tag, "_reti_err"}, bus.reti_err, 0);
  endtask

  // Scoreboard: every pc_load pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (clr && bus.pc_load) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pc_load", exp_q.size(), 1);
      end else begin
        got = exp_q.pop_front();
        check("sb_pc_load_val", bus.pc_load_val, got.pc);
        check("sb_flags_restore", bus.flags_restore, got.restore);
        if (got.restore) check("sb_flags_out", bus.flags_out, got.flags);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_pending  = 1'b0;
    bus.isr_addr   = '0;
    bus.pc_next    = '0;
    bus.flags_in   = '0;
    bus.instr_done = 1'b0;
    bus.reti       = 1'b0;
    bus.gie_set    = 1'b0;
    bus.gie_clr    = 1'b0;

    // Reset state
    tick();
    tick();
    check_reset("reset");
    clr = 1'b1;
    tick();

    // Basic take/return: vector 210, return 37, flags 0010
    bus.gie_set = 1'b1;
    tick();
    bus.gie_set = 1'b0;
    check("gie_idle_irq_enable", bus.irq_enable, 1);
    bus.i_pending = 1'b1;
    bus.isr_addr  = 8'd210;
    bus.pc_next   = 8'd37;
    bus.flags_in  = 4'b0010;
    expect_load(8'd210, 1'b0, '0);
    boundary(1'b0);
    check("ack_i_clr", bus.i_clr, 1);
    check("ack_stall", bus.stall, 1);
    check("ack_pc_load", bus.pc_load, 0);
    bus.i_pending  = 1'b0;
    bus.isr_addr   = 8'd99;
    bus.instr_done = 1'b1;
    bus.reti       = 1'b1;
    tick();
    bus.instr_done = 1'b0;
    bus.reti       = 1'b0;
    check("vec_pc_load", bus.pc_load, 1);
    check("vec_pc_load_val", bus.pc_load_val, 210);
    check("vec_i_clr", bus.i_clr, 0);
    check("vec_stall", bus.stall, 1);
    tick();
    check("isr_in_isr", bus.in_isr, 1);
    check("isr_irq_enable", bus.irq_enable, NESTED);
    check("isr_stall", bus.stall, 0);
    expect_load(8'd37, 1'b1, 4'b0010);
    boundary(1'b1);
    check("ret_pc_load", bus.pc_load, 1);
    check("ret_pc_load_val", bus.pc_load_val, 37);
    check("ret_flags_restore", bus.flags_restore, 1);
    check("ret_flags_out", bus.flags_out, 4'b0010);
    check("ret_in_isr", bus.in_isr, 0);
    tick();
    check("after_ret_irq_enable", bus.irq_enable, 1);
    check("after_ret_in_isr", bus.in_isr, 0);
    check("after_ret_pc_load", bus.pc_load, 0);

    // Pending ignored while gie=0, accepted after gie_set
    bus.gie_clr = 1'b1;
    tick();
    bus.gie_clr = 1'b0;
    check("gie_clr_irq_enable", bus.irq_enable, 0);
    bus.i_pending = 1'b1;
    bus.isr_addr  = 8'd230;
    bus.pc_next   = 8'd50;
    bus.flags_in  = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      boundary(1'b0);
      check("masked_i_clr", bus.i_clr, 0);
      check("masked_stall", bus.stall, 0);
    end
    bus.gie_set = 1'b1;
    tick();
    bus.gie_set = 1'b0;
    expect_load(8'd230, 1'b0, '0);
    boundary(1'b0);
    check("late_ack_i_clr", bus.i_clr, 1);
    bus.i_pending = 1'b0;
    tick();
    check("late_vec_pc_load_val", bus.pc_load_val, 230);
    tick();
    check("late_isr_in_isr", bus.in_isr, 1);
    expect_load(8'd50, 1'b1, 4'b1001);
    boundary(1'b1);
    check("late_ret_flags_out", bus.flags_out, 4'b1001);
    tick();

    // reti with no saved frame
    boundary(1'b1);
    check("reti_err_pulse", bus.reti_err, 1);
    check("reti_err_pc_load", bus.pc_load, 0);
    check("reti_err_stall", bus.stall, 0);
    tick();
    check("reti_err_clears", bus.reti_err, 0);
    check("reti_err_still_idle", bus.irq_enable, 1);

    // gie_set and gie_clr together: clear wins
    bus.gie_set = 1'b1;
    bus.gie_clr = 1'b1;
    tick();
    bus.gie_set = 1'b0;
    bus.gie_clr = 1'b0;
    check("gie_both_irq_enable", bus.irq_enable, 0);

    // Async reset while in VECTOR aborts the load
    bus.gie_set = 1'b1;
    tick();
    bus.gie_set   = 1'b0;
    bus.i_pending = 1'b1;
    bus.isr_addr  = 8'd77;
    boundary(1'b0);
    bus.i_pending = 1'b0;
    tick();
    check("abort_in_vector", bus.stall, 1);
    clr = 1'b0;
    #1;
    check_reset("abort");
    tick();
    clr = 1'b1;
    tick();
    check("abort_gie_cleared", bus.irq_enable, 0);

`ifdef NESTED_IRQ_EN
    // Two-level nest: 200 (ret 10), then 230 (ret 201)
    bus.gie_set = 1'b1;
    tick();
    bus.gie_set   = 1'b0;
    bus.i_pending = 1'b1;
    bus.isr_addr  = 8'd200;
    bus.pc_next   = 8'd10;
    bus.flags_in  = 4'b0001;
    expect_load(8'd200, 1'b0, '0);
    boundary(1'b0);
    bus.i_pending = 1'b0;
    tick();
    tick();
    check("nest1_irq_enable", bus.irq_enable, 1);
    bus.i_pending = 1'b1;
    bus.isr_addr  = 8'd230;
    bus.pc_next   = 8'd201;
    bus.flags_in  = 4'b0011;
    expect_load(8'd230, 1'b0, '0);
    boundary(1'b0);
    check("nest2_i_clr", bus.i_clr, 1);
    tick();
    check("nest2_vec", bus.pc_load_val, 230);
    tick();
    // reti takes precedence over the still-pending interrupt
    expect_load(8'd201, 1'b1, 4'b0011);
    boundary(1'b1);
    check("nest_ret1_no_i_clr", bus.i_clr, 0);
    check("nest_ret1_pc", bus.pc_load_val, 201);
    bus.i_pending = 1'b0;
    tick();
    check("nest_ret1_stays_isr", bus.in_isr, 1);
    expect_load(8'd10, 1'b1, 4'b0001);
    boundary(1'b1);
    check("nest_ret2_pc", bus.pc_load_val, 10);
    tick();
    check("nest_ret2_idle_in_isr", bus.in_isr, 0);
    check("nest_ret2_idle_enable", bus.irq_enable, 1);

    // Fill the stack to NEST_DEPTH, then a fifth accept is refused
    for (int k = 0; k < NEST_DEPTH; k++) begin
      bus.i_pending = 1'b1;
      bus.isr_addr  = 8'(100 + k);
      bus.pc_next   = 8'(20 + k);
      bus.flags_in  = 4'(k);
      check("fill_irq_enable", bus.irq_enable, 1);
      expect_load(8'(100 + k), 1'b0, '0);
      boundary(1'b0);
      bus.i_pending = 1'b0;
      check("fill_i_clr", bus.i_clr, 1);
      tick();
      tick();
    end
    check("full_irq_enable", bus.irq_enable, 0);
    bus.i_pending = 1'b1;
    boundary(1'b0);
    bus.i_pending = 1'b0;
    check("full_no_i_clr", bus.i_clr, 0);
    check("full_in_isr", bus.in_isr, 1);
    for (int k = NEST_DEPTH - 1; k >= 0; k--) begin
      expect_load(8'(20 + k), 1'b1, 4'(k));
      boundary(1'b1);
      check("unwind_pc", bus.pc_load_val, 20 + k);
      check("unwind_flags", bus.flags_out, k);
      tick();
      check("unwind_in_isr", bus.in_isr, k != 0);
    end
`endif

    tick();
    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
